cdc_xfer_arbiter: RTL and testbench
===================================

# cdc_xfer_arbiter

Source-domain controller that shares one multi-bit clock-domain-crossing channel among `N_REQ` requesters. It round-robin arbitrates the requesters and captures the winner's payload into a stable holding register. It then sequences a toggle-based req/ack handshake whose request bit is carried to the destination domain by the per-bit synchronizer, with the returning ack arriving already synchronized. One word is in flight at a time, so the holding register is guaranteed stable while the destination samples it.

## Interface
- `N_REQ`, 4: number of requesters, 2..16.
- `DATA_W`, 32: payload width.
- `clk` input 1: source-domain clock; the only clock.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: per-requester payload valid.
- `req_data` input N_REQ*DATA_W: flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready` output N_REQ: one-hot accept pulse; a payload transfers when valid&ready.
- `xfer_data` output DATA_W: holding register, routed to the destination domain.
- `xfer_req` output 1: request toggle, routed to the destination through the synchronizer.
- `xfer_ack_sync` input 1: ack toggle from the destination, already synchronized into `clk`.
- `grant_id` output $clog2(N_REQ): index of the requester whose word is in flight.
- `busy` output 1: high in SEND and WAIT_ACK.
- `done` output 1: one-cycle pulse when an ack completes a transfer.
- `xfer_cnt` output 32: count of completed transfers.

## Operation
- FSM has three states: IDLE, SEND, WAIT_ACK.
- **IDLE**
  - Acceptance requires `xfer_ack_sync == xfer_req`, i.e. no stale handshake is outstanding. It also requires at least one `req_valid`.
  - The round-robin winner is the first valid index strictly after the last granted index, wrapping modulo N_REQ.
  - In the accept cycle, `req_ready[winner]` is driven high combinationally, `req_data[winner]` is registered into `xfer_data`, `grant_id` is registered, and the FSM moves to SEND.
- **SEND**: `xfer_req` inverts; the FSM moves to WAIT_ACK.
- **WAIT_ACK**
  - `xfer_data` and `grant_id` are held.
  - When `xfer_ack_sync == xfer_req`, `done` pulses, `xfer_cnt` increments, the round-robin pointer updates to `grant_id`, and the FSM moves to IDLE.
- `req_ready` is never high outside IDLE, and never for more than one requester at a time.
- A requester that deasserts `req_valid` before being granted is simply skipped; there is no abort.
- `xfer_cnt` wraps at 2^32 with no saturation.

## Timing
- Reset values:
  - state IDLE
  - `xfer_req` 0, `xfer_data` 0, `grant_id` 0
  - `req_ready` 0, `busy` 0, `done` 0, `xfer_cnt` 0
  - round-robin pointer at N_REQ-1, so requester 0 wins first.
- Accept at cycle T:
  - `xfer_data` is valid at T+1; the SEND state also occupies T+1.
  - `xfer_req` toggles at T+2, so data is stable for at least one cycle before the toggle.
  - `done` is asserted in the cycle where `xfer_ack_sync` matches `xfer_req`; the next accept can happen one cycle later.
- Minimum per-word occupancy is 3 cycles plus the ack round trip.
- `req_valid` high in the same cycle as `done`: not accepted that cycle; accepted the following cycle.
- Reset mid-transfer:
  - The FSM returns to IDLE and `xfer_req` returns to 0.
  - If `xfer_ack_sync` is still 1 from the aborted transfer, IDLE accepts nothing until it reads 0.
  - The destination domain must be reset together with this block.
- `xfer_ack_sync` changing while in IDLE or SEND is ignored; only a match in WAIT_ACK completes a transfer.

## Configuration
- Macro: `CDC_XFER_ARBITER_STATS_EN`.
- Defined: `xfer_cnt` is a 32-bit counter behaving as described above.
- Undefined: the counter logic is removed and `xfer_cnt` is tied to 0. The port is always present.

## Structure
- Package `cdc_xfer_pkg` holds:
  - `xfer_state_t`, an enum {IDLE, SEND, WAIT_ACK};
  - the `XFER_CNT_W = 32` constant;
  - an `id_w(n)` function returning max(1, $clog2(n)).
- Sub-module `rr_arbiter`: combinational round-robin pick.
  - Inputs: `req` vector and `last` pointer.
  - Outputs: one-hot `grant` and encoded index.
  - Reusable elsewhere in the codebase.
- Top level holds the FSM, holding register, toggle register, pointer register and counter.

## Test plan
- **Reset then single request**: requester 2 valid with data 0xA5A5_0002 → ready[2] pulses; `xfer_data`=0xA5A5_0002 one cycle later; `xfer_req` 0→1 the cycle after; model ack after 4 cycles → `done` pulse; `xfer_cnt`=1.
- **All four valid continuously**: grants follow 0,1,2,3,0; exactly one ready pulse per handshake; `req_ready` never high in WAIT_ACK.
- **Stability**: change `req_data` of the granted requester throughout WAIT_ACK → `xfer_data` unchanged until the next accept.
- **Reset during WAIT_ACK with `xfer_ack_sync` held 1**: after reset `xfer_req`=0; no ready pulses while ack=1; first accept occurs the cycle after ack drops to 0.
- **Stats build**: without the macro, `xfer_cnt` stays 0 after 10 transfers; with the macro it reads 10.

Source files
------------

// File: rtl/cdc_xfer_pkg.sv
// cdc_xfer_pkg: shared FSM state type, counter width and id-width helper for the CDC transfer arbiter
package cdc_xfer_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK} xfer_state_t;
  localparam int XFER_CNT_W = 32;
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/cdc_xfer_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request strictly after the last granted index
module rr_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int N = 4,
  parameter int W = id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx
);
  logic         found;
  logic [W-1:0] pos;
  // scan N positions starting just after last, wrapping, and take the first requester seen
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = W'((int'(last) + k) % N);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end
endmodule

// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin shared toggle-handshake CDC channel; CDC_XFER_ARBITER_STATS_EN enables xfer_cnt
module cdc_xfer_arbiter
  import cdc_xfer_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]         xfer_data,
  output logic                      xfer_req,
  input  logic                      xfer_ack_sync,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      done,
  output logic [XFER_CNT_W-1:0]     xfer_cnt
);
  localparam int IW = id_w(N_REQ);
  xfer_state_t       state_q, state_d;
  logic [DATA_W-1:0] xfer_data_q, xfer_data_d;
  logic [IW-1:0]     grant_id_q, grant_id_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic              xfer_req_q, xfer_req_d;
  logic [N_REQ-1:0]  win_grant;
  logic [IW-1:0]     win_idx;
  logic [DATA_W-1:0] words [N_REQ];
  logic              ack_ok;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(N_REQ), .W(IW)) u_rr (
    .req   (req_valid),
    .last  (ptr_q),
    .grant (win_grant),
    .idx   (win_idx)
  );

  assign ack_ok    = xfer_ack_sync == xfer_req_q;
  assign busy      = state_q != IDLE;
  assign xfer_data = xfer_data_q;
  assign grant_id  = grant_id_q;
  assign xfer_req  = xfer_req_q;

  // accept only with no handshake outstanding; data is held one cycle before the toggle
  always_comb begin
    state_d     = state_q;
    xfer_data_d = xfer_data_q;
    grant_id_d  = grant_id_q;
    xfer_req_d  = xfer_req_q;
    ptr_d       = ptr_q;
    req_ready   = '0;
    done        = 1'b0;
    case (state_q)
      IDLE: if (ack_ok && |req_valid) begin
        req_ready   = win_grant;
        xfer_data_d = words[win_idx];
        grant_id_d  = win_idx;
        state_d     = SEND;
      end
      SEND: begin
        xfer_req_d = ~xfer_req_q;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: if (ack_ok) begin
        done    = 1'b1;
        ptr_d   = grant_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, holding, toggle and pointer registers; pointer resets so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      xfer_data_q <= '0;
      grant_id_q  <= '0;
      xfer_req_q  <= 1'b0;
      ptr_q       <= IW'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      xfer_data_q <= xfer_data_d;
      grant_id_q  <= grant_id_d;
      xfer_req_q  <= xfer_req_d;
      ptr_q       <= ptr_d;
    end
  end

`ifdef CDC_XFER_ARBITER_STATS_EN
  logic [XFER_CNT_W-1:0] cnt_q, cnt_d;
  // completed-transfer count, wrapping naturally
  always_comb cnt_d = done ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign xfer_cnt = cnt_q;
`else
  assign xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb_cdc_xfer_arbiter: randomized scoreboard bench with a transaction-level arbitration and handshake model
module tb_cdc_xfer_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
`ifdef CDC_XFER_ARBITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   xfer_data;
  logic            xfer_req;
  logic            xfer_ack_sync = 1'b0;
  logic [1:0]      grant_id;
  logic            busy, done;
  logic [31:0]     xfer_cnt;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic [7:0]  id;
  } ent_t;

  ent_t          sb[$];
  logic [DW-1:0] src [N][64];
  int            src_n [N];
  int            taken [N];
  int            checks = 0, errors = 0, cyc = 0, last_id = N - 1, m_cnt = 0, cd = 0;
  bit            chk_en = 0, in_flight = 0, toggled = 0, clr_pend = 0, m_req = 0;
  bit            ack_val = 0, force_en = 0, force_val = 0, rnd_mode = 0;

  cdc_xfer_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .xfer_data     (xfer_data),
    .xfer_req      (xfer_req),
    .xfer_ack_sync (xfer_ack_sync),
    .grant_id      (grant_id),
    .busy          (busy),
    .done          (done),
    .xfer_cnt      (xfer_cnt)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (((v >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
    return -1;
  endfunction

  function automatic bit pending();
    bit p = sb.size() != 0 || in_flight;
    for (int i = 0; i < N; i++) if (taken[i] < src_n[i]) p = 1'b1;
    return p;
  endfunction

  // requester model: present queue head while words remain, junk data otherwise
  initial begin : drv
    logic [N-1:0]    vv;
    logic [N*DW-1:0] dd;
    logic            v;
    logic [DW-1:0]   w;
    forever begin
      @(posedge clk); #1;
      vv = '0;
      dd = '0;
      for (int i = 0; i < N; i++) begin
        v  = taken[i] < src_n[i] && (!rnd_mode || $urandom_range(0, 3) != 0);
        w  = v ? src[i][taken[i]] : DW'($urandom);
        vv = vv | (N'(v) << i);
        dd = dd | ((N*DW)'(w) << (i * DW));
      end
      req_valid = vv;
      req_data  = dd;
    end
  end

  // acceptance side: expected winner from the round-robin rule, pushed to the scoreboard
  initial begin : acc
    int           w;
    logic [N-1:0] ex;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        w  = (!in_flight && xfer_ack_sync == m_req && req_valid != '0) ? rr_pick(req_valid, last_id) : -1;
        ex = (w >= 0) ? N'(1) << w : '0;
        check("req_ready", req_ready, ex);
        if (w >= 0) begin
          sb.push_back('{cyc: cyc, data: DW'(req_data >> (w * DW)), id: 8'(w)});
          taken[w]++;
          in_flight = 1'b1;
        end
      end
    end
  end

  // destination side: watches the toggle, answers with a delayed ack, pops and compares
  initial begin : dest
    bit ed;
    forever begin
      @(posedge clk); #1;
      if (clr_pend) begin
        in_flight = 1'b0;
        m_cnt++;
        clr_pend = 1'b0;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) ack_val = m_req;
      end
      xfer_ack_sync = force_en ? force_val : ack_val;
      @(negedge clk);
      if (chk_en) begin
        if (sb.size() > 0 && cyc >= int'(sb[0].cyc) + 1) begin
          if (cyc == int'(sb[0].cyc) + 2) begin
            m_req   = ~m_req;
            toggled = 1'b1;
            cd      = $urandom_range(1, 4);
          end
          check("xfer_data", xfer_data, sb[0].data);
          check("grant_id", grant_id, sb[0].id);
          check("busy_inflight", busy, 1);
          ed = toggled && xfer_ack_sync == m_req;
          check("done", done, ed);
          if (ed) begin
            last_id = sb[0].id;
            void'(sb.pop_front());
            toggled  = 1'b0;
            clr_pend = 1'b1;
          end
        end else begin
          check("busy_idle", busy, 0);
          check("done_idle", done, 0);
        end
        check("xfer_req", xfer_req, m_req);
        check("xfer_cnt", xfer_cnt, STATS ? m_cnt : 0);
      end
    end
  end

  task automatic do_reset(input bit hold_ack);
    @(posedge clk); #2;
    chk_en = 1'b0;
    rst    = 1'b1;
    if (hold_ack) begin
      force_en  = 1'b1;
      force_val = 1'b1;
    end
    repeat (2) @(posedge clk);
    #2;
    sb.delete();
    in_flight = 0; toggled = 0; clr_pend = 0; m_req = 0; ack_val = 0;
    last_id = N - 1; m_cnt = 0; cd = 0;
    for (int i = 0; i < N; i++) begin
      src_n[i] = 0;
      taken[i] = 0;
    end
    rst    = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic drain();
    int t = 0;
    while (pending() && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("drain_timeout", t < 2000, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic load(input int i, input logic [DW-1:0] w);
    src[i][src_n[i]] = w;
    src_n[i]++;
  endtask

  initial begin : main
    int t;
    for (int i = 0; i < N; i++) begin
      src_n[i] = 0;
      taken[i] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_xfer_data", xfer_data, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_xfer_req", xfer_req, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_xfer_cnt", xfer_cnt, 0);
    @(posedge clk); #2;
    load(2, 32'hA5A5_0002);
    drain();
    @(negedge clk);
    check("single_hold", xfer_data, 32'hA5A5_0002);
    check("single_cnt", xfer_cnt, STATS ? 1 : 0);

    do_reset(0);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) load(i, {8'(i), 8'(k), 16'hC0DE});
    drain();

    do_reset(0);
    rnd_mode = 1'b1;
    for (int k = 0; k < 40; k++) load($urandom_range(0, N - 1), $urandom);
    drain();
    rnd_mode = 1'b0;

    for (int k = 0; k < 2; k++) load(1, $urandom);
    t = 0;
    while (!toggled && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("wait_toggle", toggled, 1);
    do_reset(1);
    for (int k = 0; k < 5; k++) begin
      load(0, $urandom);
      load(3, $urandom);
    end
    repeat (6) begin
      @(negedge clk);
      check("hold_xfer_req", xfer_req, 0);
      check("hold_no_ready", req_ready, 0);
    end
    @(posedge clk); #2;
    force_en = 1'b0;
    drain();
    @(negedge clk);
    check("final_cnt", xfer_cnt, STATS ? 10 : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
